axi4lite_reg_slave: RTL and testbench
=====================================

Name: axi4lite_reg_slave

Overview:
- AXI4-Lite slave endpoint: a bank of NUM_REGS DATA_WIDTH-bit read/write registers behind one AXI4-Lite port.
- Sits directly downstream of the interconnect/master. It is the DUT that the AXI4-Lite property checker binds to in SLAVE mode (asserting the slave channels) and MASTER mode (driving the stimulus side).
- Holds at most one outstanding transaction per direction.
- Always exposes the full register contents on a flat debug bus.

Parameters:
- ADDR_WIDTH, 32, AWADDR/ARADDR width.
- DATA_WIDTH, 32, data width; must be 32 or 64.
- STRB_WIDTH, DATA_WIDTH/8, write strobe width.
- NUM_REGS, 8, register count; power of two, at least 2.

Ports:
- ACLK  in  1  clock.
- ARESETn  in  1  asynchronous active-low reset.
- AWVALID/AWREADY  in/out  1/1  write address handshake.
- AWADDR  in  ADDR_WIDTH  write byte address.
- AWPROT  in  3  write protection.
- WVALID/WREADY  in/out  1/1  write data handshake.
- WDATA  in  DATA_WIDTH  write data.
- WSTRB  in  STRB_WIDTH  byte enables.
- BVALID/BREADY  out/in  1/1  write response handshake.
- BRESP  out  2  write response.
- ARVALID/ARREADY  in/out  1/1  read address handshake.
- ARADDR  in  ADDR_WIDTH  read byte address.
- ARPROT  in  3  read protection.
- RVALID/RREADY  out/in  1/1  read data handshake.
- RDATA  out  DATA_WIDTH  read data.
- RRESP  out  2  read response.
- regs_o  out  NUM_REGS*DATA_WIDTH  flat register contents; register i occupies slice [i*DATA_WIDTH +: DATA_WIDTH].

Behaviour:
- Reset (ARESETn=0, asynchronous): every output is 0. That covers all READY and VALID signals, BRESP, RRESP, RDATA and all registers. The first READY rises in the cycle after ARESETn deasserts. Reset mid-transaction discards the captured address/data and any pending response; no partial write commits.
- Decode: idx = addr[LSB +: log2(NUM_REGS)], where LSB = log2(STRB_WIDTH). The low LSB bits are ignored. Any set bit above the index field means out of range, giving RESP=SLVERR (2'b10). In-range accesses give OKAY (2'b00).
- Write path, per-channel capture flags aw_full and w_full, all outputs registered:
  - AWREADY = !aw_full && !BVALID. WREADY = !w_full && !BVALID.
  - AW and W are accepted independently, in either order or in the same cycle.
  - Commit occurs in the cycle after both flags are set. In-range: byte k of reg[idx] is written where WSTRB[k]=1. Out of range: no state change.
  - The same edge clears both flags, sets BVALID=1 and latches BRESP.
  - Write latency: 2 cycles from the later of the AW/W handshakes to BVALID.
  - BVALID and BRESP hold until BREADY. BVALID falls on the handshake edge. AWREADY/WREADY rise the cycle after that.
  - BVALID is never raised without both an AW and a W handshake since the last B handshake.
- Read path:
  - ARREADY = !RVALID && !ar_pending. ARREADY drops on the edge following an AR handshake.
  - RVALID rises 1 cycle after the AR handshake, with RDATA = reg[idx] (0 when out of range) and RRESP latched.
  - RVALID, RDATA and RRESP are stable until RREADY. ARREADY returns 1 the cycle after the R handshake.
- Simultaneous write commit and AR handshake to the same register: the read returns the pre-write value.
- Read and write paths are fully independent; either may stall indefinitely on BREADY/RREADY.
- Transaction counts never exceed 1 per channel.

Optional Feature:
- Macro AXI4LITE_SLV_PRIV_ONLY_EN.
- Defined: an access with AxPROT[0]=0 (unprivileged) returns SLVERR. An unprivileged write commits nothing; an unprivileged read returns RDATA=0. SLVERR takes precedence regardless of range.
- Undefined: AWPROT/ARPROT are ignored entirely; no extra logic is synthesized.

Decomposition:
- Package axi4lite_pkg holds:
  - resp_t enum: OKAY=2'b00, EXOKAY=2'b01, SLVERR=2'b10, DECERR=2'b11.
  - Agent-type constants: MASTER=0, SLAVE=1, MONITOR=2, CONSTRAINT=3.
  - Function clog2-based idx width helper.
- One sub-module, axi4lite_reg_bank: NUM_REGS x DATA_WIDTH storage with byte-strobe write port, combinational read port and flat regs_o. Asynchronous reset to 0.

Test Plan:
- Reset, then AW(0x04) and W(0xDEADBEEF, WSTRB=4'hF) in the same cycle with BREADY=1 -> BVALID 2 cycles later, BRESP=0. A read of 0x04 returns 0xDEADBEEF with RRESP=0 one cycle after the AR handshake.
- W 3 cycles before AW(0x08), WSTRB=4'b0101, data 0x11223344 onto 0xFFFFFFFF -> reg2=0xFF22FF44. BVALID is not raised before the AW handshake.
- Hold BREADY=0 for 5 cycles -> BVALID/BRESP stable and AWREADY=WREADY=0 throughout. BVALID falls the cycle after BREADY=1.
- Read 0x40 (out of range, NUM_REGS=8) with RREADY=0 for 4 cycles -> RVALID stable, RDATA=0, RRESP=2'b10 throughout; ARREADY=0 until the handshake.
- Assert ARESETn=0 with AW captured and W pending -> all outputs 0 and registers 0. After release, reg1 still reads 0 and no stray BVALID appears.
- With AXI4LITE_SLV_PRIV_ONLY_EN defined: write 0x0 with AWPROT=3'b000 -> BRESP=2'b10 and reg0 unchanged. The same write with AWPROT=3'b001 gives OKAY and commits.

Source files
------------

// File: rtl/axi4lite_pkg.sv
// Shared types and helpers for the AXI4-Lite register slave.
package axi4lite_pkg;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    EXOKAY = 2'b01,
    SLVERR = 2'b10,
    DECERR = 2'b11
  } resp_t;

  // Agent roles used by the property checker that binds to this slave.
  localparam int MASTER     = 0;
  localparam int SLAVE      = 1;
  localparam int MONITOR    = 2;
  localparam int CONSTRAINT = 3;

  // Width of a register index for n registers (at least 1 bit).
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/axi4lite_reg_slave_if.sv
// AXI4-Lite bus bundle with master and slave views.
interface axi4lite_reg_slave_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int STRB_WIDTH = DATA_WIDTH / 8
) ();

  logic                  AWVALID;
  logic                  AWREADY;
  logic [ADDR_WIDTH-1:0] AWADDR;
  logic [2:0]            AWPROT;
  logic                  WVALID;
  logic                  WREADY;
  logic [DATA_WIDTH-1:0] WDATA;
  logic [STRB_WIDTH-1:0] WSTRB;
  logic                  BVALID;
  logic                  BREADY;
  logic [1:0]            BRESP;
  logic                  ARVALID;
  logic                  ARREADY;
  logic [ADDR_WIDTH-1:0] ARADDR;
  logic [2:0]            ARPROT;
  logic                  RVALID;
  logic                  RREADY;
  logic [DATA_WIDTH-1:0] RDATA;
  logic [1:0]            RRESP;

  modport slave (
    input  AWVALID, AWADDR, AWPROT, WVALID, WDATA, WSTRB, BREADY,
    input  ARVALID, ARADDR, ARPROT, RREADY,
    output AWREADY, WREADY, BVALID, BRESP, ARREADY, RVALID, RDATA, RRESP
  );

  modport master (
    output AWVALID, AWADDR, AWPROT, WVALID, WDATA, WSTRB, BREADY,
    output ARVALID, ARADDR, ARPROT, RREADY,
    input  AWREADY, WREADY, BVALID, BRESP, ARREADY, RVALID, RDATA, RRESP
  );

endinterface

// File: rtl/axi4lite_reg_bank.sv
// NUM_REGS x DATA_WIDTH register storage: byte-strobed write port,
// combinational read port, flat view of all registers.
module axi4lite_reg_bank
  import axi4lite_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int STRB_WIDTH = DATA_WIDTH / 8,
  parameter int NUM_REGS   = 8,
  parameter int IDXW       = idx_width(NUM_REGS)
) (
  input  logic                           ACLK,
  input  logic                           ARESETn,
  input  logic                           we,
  input  logic [IDXW-1:0]                widx,
  input  logic [DATA_WIDTH-1:0]          wdata,
  input  logic [STRB_WIDTH-1:0]          wstrb,
  input  logic [IDXW-1:0]                ridx,
  output logic [DATA_WIDTH-1:0]          rdata,
  output logic [NUM_REGS*DATA_WIDTH-1:0] regs_o
);

  logic [NUM_REGS-1:0][DATA_WIDTH-1:0] mem;

  // Register storage with per-byte write enables.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      mem <= '0;
    end else if (we) begin
      for (int unsigned k = 0; k < STRB_WIDTH; k++) begin
        if (wstrb[k]) mem[widx][k*8 +: 8] <= wdata[k*8 +: 8];
      end
    end
  end

  // Combinational read port and flat debug view.
  always_comb begin
    rdata  = mem[ridx];
    regs_o = mem;
  end

endmodule

// File: rtl/axi4lite_reg_slave.sv
// AXI4-Lite slave exposing a bank of read/write registers.
// Optional build macro: AXI4LITE_SLV_PRIV_ONLY_EN (unprivileged accesses get SLVERR).
module axi4lite_reg_slave
  import axi4lite_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int STRB_WIDTH = DATA_WIDTH / 8,
  parameter int NUM_REGS   = 8
) (
  input  logic                           ACLK,
  input  logic                           ARESETn,
  axi4lite_reg_slave_if.slave            s_axi,
  output logic [NUM_REGS*DATA_WIDTH-1:0] regs_o
);

  localparam int LSB  = $clog2(STRB_WIDTH);
  localparam int IDXW = idx_width(NUM_REGS);

  typedef enum logic {RD_IDLE, RD_RESP} rd_state_t;

  logic                  aw_full, w_full;
  logic                  awready, wready, bvalid;
  resp_t                 bresp;
  logic [ADDR_WIDTH-1:0] aw_addr;
  logic [DATA_WIDTH-1:0] w_data;
  logic [STRB_WIDTH-1:0] w_strb;
  logic                  aw_hs, w_hs, b_hs, commit;
  logic                  wr_oor, wr_ok;

  rd_state_t             rd_state, rd_next;
  logic                  arready;
  logic [DATA_WIDTH-1:0] rdata;
  resp_t                 rresp;
  logic                  ar_hs, rd_oor, rd_ok;
  logic [DATA_WIDTH-1:0] bank_rdata;

  assign aw_hs  = s_axi.AWVALID && awready;
  assign w_hs   = s_axi.WVALID  && wready;
  assign b_hs   = bvalid && s_axi.BREADY;
  assign commit = aw_full && w_full;
  assign ar_hs  = s_axi.ARVALID && arready;

  assign wr_oor = |aw_addr[ADDR_WIDTH-1:LSB+IDXW];
  assign rd_oor = |s_axi.ARADDR[ADDR_WIDTH-1:LSB+IDXW];

`ifdef AXI4LITE_SLV_PRIV_ONLY_EN
  logic aw_priv;
  logic unused_bits;
  assign wr_ok = !wr_oor && aw_priv;
  assign rd_ok = !rd_oor && s_axi.ARPROT[0];
  assign unused_bits = ^{aw_addr[LSB-1:0], s_axi.ARADDR[LSB-1:0],
                         s_axi.AWPROT[2:1], s_axi.ARPROT[2:1]};

  // Privilege bit travels with the captured write address.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn)   aw_priv <= 1'b0;
    else if (aw_hs) aw_priv <= s_axi.AWPROT[0];
  end
`else
  logic unused_bits;
  assign wr_ok = !wr_oor;
  assign rd_ok = !rd_oor;
  assign unused_bits = ^{aw_addr[LSB-1:0], s_axi.ARADDR[LSB-1:0],
                         s_axi.AWPROT, s_axi.ARPROT};
`endif

  // Write path: independent AW/W capture, commit once both are held.
  // READY is recomputed from current state, so it drops on its own
  // handshake edge and only returns one cycle after the B handshake.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      aw_full <= 1'b0;
      w_full  <= 1'b0;
      awready <= 1'b0;
      wready  <= 1'b0;
      bvalid  <= 1'b0;
      bresp   <= OKAY;
      aw_addr <= '0;
      w_data  <= '0;
      w_strb  <= '0;
    end else begin
      awready <= !aw_hs && !aw_full && !bvalid;
      wready  <= !w_hs && !w_full && !bvalid;
      if (b_hs) bvalid <= 1'b0;
      if (commit) begin
        aw_full <= 1'b0;
        w_full  <= 1'b0;
        bvalid  <= 1'b1;
        bresp   <= wr_ok ? OKAY : SLVERR;
      end else begin
        if (aw_hs) begin
          aw_full <= 1'b1;
          aw_addr <= s_axi.AWADDR;
        end
        if (w_hs) begin
          w_full <= 1'b1;
          w_data <= s_axi.WDATA;
          w_strb <= s_axi.WSTRB;
        end
      end
    end
  end

  // Read FSM state register.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) rd_state <= RD_IDLE;
    else          rd_state <= rd_next;
  end

  // Read FSM next state: one outstanding read at a time.
  always_comb begin
    rd_next = rd_state;
    unique case (rd_state)
      RD_IDLE: if (ar_hs)          rd_next = RD_RESP;
      RD_RESP: if (s_axi.RREADY)   rd_next = RD_IDLE;
      default:                     rd_next = RD_IDLE;
    endcase
  end

  // Read datapath: sample bank at AR handshake (pre-write on a same-edge commit).
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      arready <= 1'b0;
      rdata   <= '0;
      rresp   <= OKAY;
    end else begin
      arready <= !ar_hs && (rd_state == RD_IDLE);
      if (ar_hs) begin
        rdata <= rd_ok ? bank_rdata : '0;
        rresp <= rd_ok ? OKAY : SLVERR;
      end
    end
  end

  axi4lite_reg_bank #(
    .DATA_WIDTH (DATA_WIDTH),
    .STRB_WIDTH (STRB_WIDTH),
    .NUM_REGS   (NUM_REGS),
    .IDXW       (IDXW)
  ) u_bank (
    .ACLK    (ACLK),
    .ARESETn (ARESETn),
    .we      (commit && wr_ok),
    .widx    (aw_addr[LSB +: IDXW]),
    .wdata   (w_data),
    .wstrb   (w_strb),
    .ridx    (s_axi.ARADDR[LSB +: IDXW]),
    .rdata   (bank_rdata),
    .regs_o  (regs_o)
  );

  assign s_axi.AWREADY = awready;
  assign s_axi.WREADY  = wready;
  assign s_axi.BVALID  = bvalid;
  assign s_axi.BRESP   = bresp;
  assign s_axi.ARREADY = arready;
  assign s_axi.RVALID  = (rd_state == RD_RESP);
  assign s_axi.RDATA   = rdata;
  assign s_axi.RRESP   = rresp;

endmodule

// File: tb/tb_axi4lite_reg_slave.sv
// Directed testbench for axi4lite_reg_slave (NUM_REGS=8, 32-bit data).
module tb_axi4lite_reg_slave;

  logic         ACLK;
  logic         ARESETn;
  logic [255:0] regs;
  int           tests;
  int           fails;

  axi4lite_reg_slave_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

  axi4lite_reg_slave #(
    .ADDR_WIDTH (32),
    .DATA_WIDTH (32),
    .NUM_REGS   (8)
  ) dut (
    .ACLK    (ACLK),
    .ARESETn (ARESETn),
    .s_axi   (bus),
    .regs_o  (regs)
  );

  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not reach its end");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                          input logic [2:0] p, output logic [1:0] r);
    int n;
    n = 0;
    while (!(bus.AWREADY && bus.WREADY) && n < 20) begin tick(); n++; end
    bus.AWVALID = 1'b1; bus.AWADDR = a; bus.AWPROT = p;
    bus.WVALID  = 1'b1; bus.WDATA  = d; bus.WSTRB  = s;
    bus.BREADY  = 1'b0;
    tick();
    bus.AWVALID = 1'b0; bus.WVALID = 1'b0;
    n = 0;
    while (!bus.BVALID && n < 20) begin tick(); n++; end
    chk("wr_bvalid_seen", bus.BVALID, 1);
    r = bus.BRESP;
    bus.BREADY = 1'b1;
    tick();
    bus.BREADY = 1'b0;
  endtask

  task automatic do_read(input logic [31:0] a, input logic [2:0] p,
                         output logic [31:0] d, output logic [1:0] r);
    int n;
    n = 0;
    while (!bus.ARREADY && n < 20) begin tick(); n++; end
    bus.ARVALID = 1'b1; bus.ARADDR = a; bus.ARPROT = p;
    tick();
    bus.ARVALID = 1'b0;
    n = 0;
    while (!bus.RVALID && n < 20) begin tick(); n++; end
    chk("rd_rvalid_seen", bus.RVALID, 1);
    d = bus.RDATA;
    r = bus.RRESP;
    bus.RREADY = 1'b1;
    tick();
    bus.RREADY = 1'b0;
  endtask

  initial begin
    logic [1:0]   r;
    logic [31:0]  d;
    logic [255:0] exp_regs;
    int           n;
    tests = 0;
    fails = 0;
    ARESETn = 1'b0;
    bus.AWVALID = 0; bus.AWADDR = '0; bus.AWPROT = '0;
    bus.WVALID = 0;  bus.WDATA = '0;  bus.WSTRB = '0;
    bus.BREADY = 0;
    bus.ARVALID = 0; bus.ARADDR = '0; bus.ARPROT = '0;
    bus.RREADY = 0;

    // Reset state
    tick(); tick();
    chk("rst_awready", bus.AWREADY, 0);
    chk("rst_wready", bus.WREADY, 0);
    chk("rst_arready", bus.ARREADY, 0);
    chk("rst_bvalid", bus.BVALID, 0);
    chk("rst_rvalid", bus.RVALID, 0);
    chk("rst_rdata", bus.RDATA, 0);
    chk("rst_regs", regs, 0);
    ARESETn = 1'b1;
    tick();
    chk("rel_awready", bus.AWREADY, 1);
    chk("rel_wready", bus.WREADY, 1);
    chk("rel_arready", bus.ARREADY, 1);

    // AW and W in the same cycle, BREADY held high
    bus.AWVALID = 1; bus.AWADDR = 32'h04; bus.AWPROT = 3'b001;
    bus.WVALID = 1;  bus.WDATA = 32'hDEADBEEF; bus.WSTRB = 4'hF;
    bus.BREADY = 1;
    tick();
    bus.AWVALID = 0; bus.WVALID = 0;
    chk("t1_bvalid_lat1", bus.BVALID, 0);
    chk("t1_awready_drop", bus.AWREADY, 0);
    tick();
    chk("t1_bvalid_lat2", bus.BVALID, 1);
    chk("t1_bresp", bus.BRESP, 2'b00);
    chk("t1_reg1", regs[63:32], 32'hDEADBEEF);
    tick();
    chk("t1_bvalid_fall", bus.BVALID, 0);
    chk("t1_awready_still0", bus.AWREADY, 0);
    tick();
    chk("t1_awready_back", bus.AWREADY, 1);
    bus.BREADY = 0;

    // Read back 0x04
    bus.ARVALID = 1; bus.ARADDR = 32'h04; bus.ARPROT = 3'b001;
    tick();
    bus.ARVALID = 0;
    chk("t1_rvalid", bus.RVALID, 1);
    chk("t1_rdata", bus.RDATA, 32'hDEADBEEF);
    chk("t1_rresp", bus.RRESP, 2'b00);
    chk("t1_arready_drop", bus.ARREADY, 0);
    bus.RREADY = 1;
    tick();
    chk("t1_rvalid_fall", bus.RVALID, 0);
    chk("t1_arready_still0", bus.ARREADY, 0);
    tick();
    chk("t1_arready_back", bus.ARREADY, 1);
    bus.RREADY = 0;

    // W three cycles ahead of AW, partial strobes onto all-ones
    do_write(32'h08, 32'hFFFFFFFF, 4'hF, 3'b001, r);
    chk("t2_pre_bresp", r, 2'b00);
    n = 0;
    while (!bus.WREADY && n < 20) begin tick(); n++; end
    bus.WVALID = 1; bus.WDATA = 32'h11223344; bus.WSTRB = 4'b0101;
    tick();
    bus.WVALID = 0;
    chk("t2_nobvalid_0", bus.BVALID, 0);
    tick();
    chk("t2_nobvalid_1", bus.BVALID, 0);
    tick();
    chk("t2_nobvalid_2", bus.BVALID, 0);
    bus.AWVALID = 1; bus.AWADDR = 32'h08; bus.AWPROT = 3'b001;
    tick();
    bus.AWVALID = 0;
    chk("t2_nobvalid_aw", bus.BVALID, 0);
    tick();
    chk("t2_bvalid", bus.BVALID, 1);
    chk("t2_reg2", regs[95:64], 32'hFF22FF44);

    // BREADY stall
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("t3_bvalid_hold", bus.BVALID, 1);
      chk("t3_bresp_hold", bus.BRESP, 2'b00);
      chk("t3_awready_low", bus.AWREADY, 0);
      chk("t3_wready_low", bus.WREADY, 0);
    end
    bus.BREADY = 1;
    tick();
    chk("t3_bvalid_fall", bus.BVALID, 0);
    bus.BREADY = 0;

    // Out-of-range read with RREADY stall
    n = 0;
    while (!bus.ARREADY && n < 20) begin tick(); n++; end
    bus.ARVALID = 1; bus.ARADDR = 32'h40; bus.ARPROT = 3'b001;
    tick();
    bus.ARVALID = 0;
    chk("t4_rvalid", bus.RVALID, 1);
    chk("t4_rdata", bus.RDATA, 0);
    chk("t4_rresp", bus.RRESP, 2'b10);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("t4_rvalid_hold", bus.RVALID, 1);
      chk("t4_rdata_hold", bus.RDATA, 0);
      chk("t4_rresp_hold", bus.RRESP, 2'b10);
      chk("t4_arready_low", bus.ARREADY, 0);
    end
    bus.RREADY = 1;
    tick();
    chk("t4_rvalid_fall", bus.RVALID, 0);
    bus.RREADY = 0;

    // Out-of-range write leaves registers untouched
    do_write(32'h20, 32'hCAFEF00D, 4'hF, 3'b001, r);
    chk("oor_wr_bresp", r, 2'b10);
    exp_regs = '0;
    exp_regs[63:32] = 32'hDEADBEEF;
    exp_regs[95:64] = 32'hFF22FF44;
    chk("oor_wr_regs", regs, exp_regs);

    // Write commit and AR handshake to reg3 on the same edge
    n = 0;
    while (!(bus.AWREADY && bus.WREADY && bus.ARREADY) && n < 20) begin tick(); n++; end
    bus.AWVALID = 1; bus.AWADDR = 32'h0C; bus.AWPROT = 3'b001;
    bus.WVALID = 1;  bus.WDATA = 32'hA5A5A5A5; bus.WSTRB = 4'hF;
    tick();
    bus.AWVALID = 0; bus.WVALID = 0;
    bus.ARVALID = 1; bus.ARADDR = 32'h0C; bus.ARPROT = 3'b001;
    tick();
    bus.ARVALID = 0;
    chk("col_bvalid", bus.BVALID, 1);
    chk("col_rvalid", bus.RVALID, 1);
    chk("col_rdata_old", bus.RDATA, 0);
    chk("col_reg3_new", regs[127:96], 32'hA5A5A5A5);
    bus.BREADY = 1; bus.RREADY = 1;
    tick();
    bus.BREADY = 0; bus.RREADY = 0;

`ifdef AXI4LITE_SLV_PRIV_ONLY_EN
    do_write(32'h00, 32'h11111111, 4'hF, 3'b000, r);
    chk("priv_wr_unpriv_bresp", r, 2'b10);
    chk("priv_wr_unpriv_reg0", regs[31:0], 0);
    do_write(32'h00, 32'h11111111, 4'hF, 3'b001, r);
    chk("priv_wr_priv_bresp", r, 2'b00);
    chk("priv_wr_priv_reg0", regs[31:0], 32'h11111111);
    do_read(32'h00, 3'b000, d, r);
    chk("priv_rd_unpriv_data", d, 0);
    chk("priv_rd_unpriv_rresp", r, 2'b10);
`else
    do_write(32'h00, 32'h11111111, 4'hF, 3'b000, r);
    chk("prot_ignored_bresp", r, 2'b00);
    chk("prot_ignored_reg0", regs[31:0], 32'h11111111);
    do_read(32'h00, 3'b000, d, r);
    chk("prot_ignored_rdata", d, 32'h11111111);
    chk("prot_ignored_rresp", r, 2'b00);
`endif

    // Reset with AW captured and W pending
    n = 0;
    while (!bus.AWREADY && n < 20) begin tick(); n++; end
    bus.AWVALID = 1; bus.AWADDR = 32'h04; bus.AWPROT = 3'b001;
    tick();
    bus.AWVALID = 0;
    bus.WVALID = 1; bus.WDATA = 32'h12345678; bus.WSTRB = 4'hF;
    ARESETn = 1'b0;
    #1;
    chk("mrst_awready", bus.AWREADY, 0);
    chk("mrst_wready", bus.WREADY, 0);
    chk("mrst_arready", bus.ARREADY, 0);
    chk("mrst_bvalid", bus.BVALID, 0);
    chk("mrst_bresp", bus.BRESP, 0);
    chk("mrst_rvalid", bus.RVALID, 0);
    chk("mrst_rresp", bus.RRESP, 0);
    chk("mrst_rdata", bus.RDATA, 0);
    chk("mrst_regs", regs, 0);
    bus.WVALID = 0;
    tick(); tick();
    ARESETn = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("mrst_no_stray_bvalid", bus.BVALID, 0);
    end
    do_read(32'h04, 3'b001, d, r);
    chk("mrst_reg1_rdata", d, 0);
    chk("mrst_reg1_rresp", r, 2'b00);
    chk("mrst_regs_after", regs, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
